// File: rtl/sink_checker.sv
// sink_checker: flit sink that paces the transmitter with a ready pattern,
// tracks packet framing, accumulates an XOR checksum per packet and keeps
// saturating flit/packet counters plus a sticky first-error record.
module sink_checker #(
    parameter int FLIT_DATA_WIDTH = 32,
    parameter int INIT_WAIT       = 5,
    parameter int STALL_PERIOD    = 0,
    localparam int FLIT_WIDTH     = FLIT_DATA_WIDTH + 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [FLIT_WIDTH-1:0]      flit,
    input  logic                       valid,
    output logic                       ready,
    output logic                       pkt_done,
    output logic [FLIT_DATA_WIDTH-1:0] pkt_checksum,
    output logic [15:0]                flit_count,
    output logic [15:0]                pkt_count,
    output logic                       error,
    output logic [1:0]                 err_code
);

    typedef enum logic [1:0] {
        FT_PAYLOAD = 2'b00,
        FT_HEADER  = 2'b01,
        FT_LAST    = 2'b10,
        FT_SINGLE  = 2'b11
    } flit_type_e;

    typedef enum logic {
        WAIT_HDR = 1'b0,
        IN_PKT   = 1'b1
    } state_e;

    localparam logic [1:0] ERR_UNEXP_BODY = 2'b01;
    localparam logic [1:0] ERR_UNEXP_HDR  = 2'b10;

    localparam int INIT_W  = (INIT_WAIT > 0) ? $clog2(INIT_WAIT + 1) : 1;
    localparam int STALL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    logic [INIT_W-1:0]  init_cnt;
    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_nxt;
    logic               post_init;

    state_e                     state, state_nxt;
    logic [FLIT_DATA_WIDTH-1:0] run_sum, run_sum_nxt;
    logic [FLIT_DATA_WIDTH-1:0] done_sum;
    logic                       complete;
    logic                       err_hit;
    logic [1:0]                 err_cause;

    flit_type_e                 ftype;
    logic [FLIT_DATA_WIDTH-1:0] fdata;
    logic                       xfer;

    assign ftype = flit_type_e'(flit[FLIT_WIDTH-1 -: 2]);
    assign fdata = flit[FLIT_DATA_WIDTH-1:0];
    assign xfer  = valid && ready;

    // The cycle that ready is being computed for lies past the init phase.
    assign post_init = (int'(init_cnt) + 1 >= INIT_WAIT);
    // Position of the upcoming cycle within the stall period; 0 means stall.
    assign stall_nxt = (stall_cnt == STALL_W'(STALL_PERIOD - 1)) ? '0 : stall_cnt + 1'b1;

    // Ready pacing: hold low during init, then apply the periodic stall pattern.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            init_cnt  <= '0;
            stall_cnt <= '0;
            ready     <= 1'b0;
        end else begin
            if (init_cnt != INIT_W'(INIT_WAIT)) begin
                init_cnt <= init_cnt + 1'b1;
            end
            if (!post_init) begin
                ready <= 1'b0;
            end else if (STALL_PERIOD == 0) begin
                ready <= 1'b1;
            end else begin
                stall_cnt <= stall_nxt;
                ready     <= (stall_nxt != '0);
            end
        end
    end

    // Packet framing decode: next state, running checksum, completion and errors.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned and no latch is inferred.
        state_nxt   = state;
        run_sum_nxt = run_sum;
        done_sum    = fdata;
        complete    = 1'b0;
        err_hit     = 1'b0;
        err_cause   = 2'b00;
        if (xfer) begin
            if (state == IN_PKT && (ftype == FT_HEADER || ftype == FT_SINGLE)) begin
                err_hit   = 1'b1;
                err_cause = ERR_UNEXP_HDR;
            end
            unique case (ftype)
                FT_HEADER: begin
                    run_sum_nxt = fdata;
                    state_nxt   = IN_PKT;
                end
                FT_SINGLE: begin
                    complete  = 1'b1;
                    done_sum  = fdata;
                    state_nxt = WAIT_HDR;
                end
                FT_PAYLOAD: begin
                    if (state == IN_PKT) begin
                        run_sum_nxt = run_sum ^ fdata;
                    end else begin
                        err_hit   = 1'b1;
                        err_cause = ERR_UNEXP_BODY;
                    end
                end
                FT_LAST: begin
                    if (state == IN_PKT) begin
                        complete  = 1'b1;
                        done_sum  = run_sum ^ fdata;
                        state_nxt = WAIT_HDR;
                    end else begin
                        err_hit   = 1'b1;
                        err_cause = ERR_UNEXP_BODY;
                    end
                end
                default: ;
            endcase
        end
    end

    // Packet state, registered outputs and saturating counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= WAIT_HDR;
            run_sum      <= '0;
            pkt_done     <= 1'b0;
            pkt_checksum <= '0;
            flit_count   <= '0;
            pkt_count    <= '0;
            error        <= 1'b0;
            err_code     <= 2'b00;
        end else begin
            state    <= state_nxt;
            run_sum  <= run_sum_nxt;
            pkt_done <= complete;
            if (complete) begin
                pkt_checksum <= done_sum;
                if (pkt_count != 16'hFFFF) begin
                    pkt_count <= pkt_count + 16'd1;
                end
            end
            if (xfer && flit_count != 16'hFFFF) begin
                flit_count <= flit_count + 16'd1;
            end
            if (err_hit && !error) begin
                error    <= 1'b1;
                err_code <= err_cause;
            end
        end
    end

endmodule

// File: tb/tb_sink_checker.sv
// Testbench for sink_checker: two instances (no stall, stall period 3) driven
// by directed and random flits, compared every cycle against a packet-level
// reference model built from word lists and plain arithmetic.
module tb_sink_checker;

    localparam int DW = 32;
    localparam int FW = DW + 2;
    localparam int IW = 5;

    localparam logic [1:0] T_PAY = 2'b00;
    localparam logic [1:0] T_HDR = 2'b01;
    localparam logic [1:0] T_LST = 2'b10;
    localparam logic [1:0] T_SGL = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit  [2];
    logic          valid [2];
    logic          ready [2];
    logic          done  [2];
    logic [DW-1:0] sum   [2];
    logic [15:0]   fc    [2];
    logic [15:0]   pc    [2];
    logic          err   [2];
    logic [1:0]    code  [2];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int            since   [2];
    int            plen    [2];
    logic [DW-1:0] words   [2][256];
    logic          m_ready [2];
    logic          m_done  [2];
    logic [DW-1:0] m_sum   [2];
    int            m_fc    [2];
    int            m_pc    [2];
    logic          m_err   [2];
    logic [1:0]    m_code  [2];
    int            done_seen [2];

    sink_checker #(.FLIT_DATA_WIDTH(DW), .INIT_WAIT(IW), .STALL_PERIOD(0)) dut0 (
        .clk(clk), .rst(rst), .flit(flit[0]), .valid(valid[0]), .ready(ready[0]),
        .pkt_done(done[0]), .pkt_checksum(sum[0]), .flit_count(fc[0]),
        .pkt_count(pc[0]), .error(err[0]), .err_code(code[0])
    );

    sink_checker #(.FLIT_DATA_WIDTH(DW), .INIT_WAIT(IW), .STALL_PERIOD(3)) dut3 (
        .clk(clk), .rst(rst), .flit(flit[1]), .valid(valid[1]), .ready(ready[1]),
        .pkt_done(done[1]), .pkt_checksum(sum[1]), .flit_count(fc[1]),
        .pkt_count(pc[1]), .error(err[1]), .err_code(code[1])
    );

    always #5 clk = ~clk;

    function automatic int stall_of(input int i);
        return (i == 0) ? 0 : 3;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int i);
        since[i]   = 0;
        plen[i]    = 0;
        m_ready[i] = 1'b0;
        m_done[i]  = 1'b0;
        m_sum[i]   = '0;
        m_fc[i]    = 0;
        m_pc[i]    = 0;
        m_err[i]   = 1'b0;
        m_code[i]  = 2'b00;
    endtask

    task automatic flag(input int i, input logic [1:0] c);
        if (!m_err[i]) m_code[i] = c;
        m_err[i] = 1'b1;
    endtask

    task automatic finish_pkt(input int i, input logic [DW-1:0] s);
        m_done[i] = 1'b1;
        m_sum[i]  = s;
        if (m_pc[i] < 65535) m_pc[i]++;
    endtask

    // One clock edge of the reference model, using the inputs seen at the edge.
    task automatic model_edge(input int i);
        logic [1:0]    t;
        logic [DW-1:0] d;
        logic [DW-1:0] x;
        m_done[i] = 1'b0;
        if (valid[i] && m_ready[i]) begin
            t = flit[i][FW-1:FW-2];
            d = flit[i][DW-1:0];
            if (m_fc[i] < 65535) m_fc[i]++;
            case (t)
                T_HDR: begin
                    if (plen[i] != 0) flag(i, 2'b10);
                    words[i][0] = d;
                    plen[i] = 1;
                end
                T_SGL: begin
                    if (plen[i] != 0) flag(i, 2'b10);
                    plen[i] = 0;
                    finish_pkt(i, d);
                end
                default: begin
                    if (plen[i] == 0) begin
                        flag(i, 2'b01);
                    end else begin
                        if (plen[i] < 256) begin
                            words[i][plen[i]] = d;
                            plen[i]++;
                        end
                        if (t == T_LST) begin
                            x = '0;
                            for (int k = 0; k < plen[i]; k++) x ^= words[i][k];
                            plen[i] = 0;
                            finish_pkt(i, x);
                        end
                    end
                end
            endcase
        end
        since[i]++;
        m_ready[i] = (since[i] >= IW) &&
                     (stall_of(i) == 0 || ((since[i] - IW + 1) % stall_of(i)) != 0);
    endtask

    task automatic compare_all(input int i);
        check($sformatf("ready%0d", i),    64'(ready[i]), 64'(m_ready[i]));
        check($sformatf("pkt_done%0d", i), 64'(done[i]),  64'(m_done[i]));
        check($sformatf("checksum%0d", i), 64'(sum[i]),   64'(m_sum[i]));
        check($sformatf("flit_cnt%0d", i), 64'(fc[i]),    64'(m_fc[i]));
        check($sformatf("pkt_cnt%0d", i),  64'(pc[i]),    64'(m_pc[i]));
        check($sformatf("error%0d", i),    64'(err[i]),   64'(m_err[i]));
        check($sformatf("err_code%0d", i), 64'(code[i]),  64'(m_code[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rst) model_reset(i);
            else     model_edge(i);
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            if (done[i] === 1'b1) done_seen[i]++;
            compare_all(i);
        end
    endtask

    task automatic idle(input int n);
        valid[0] = 1'b0;
        valid[1] = 1'b0;
        for (int c = 0; c < n; c++) tick();
    endtask

    // Present one flit on instance i and hold it until the model says it was taken.
    task automatic send(input int i, input logic [1:0] t, input logic [DW-1:0] d);
        logic got;
        got      = 1'b0;
        flit[i]  = {t, d};
        valid[i] = 1'b1;
        for (int c = 0; c < 20 && !got; c++) begin
            got = m_ready[i];
            tick();
        end
        check($sformatf("send_taken%0d", i), 64'(got), 64'(1));
    endtask

    int d3_before;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            flit[i]  = '0;
            valid[i] = 1'b0;
            done_seen[i] = 0;
            model_reset(i);
        end
        #2;
        for (int i = 0; i < 2; i++) compare_all(i);
        tick();
        tick();

        // release: ready low for INIT_WAIT cycles, then high
        rst = 1'b0;
        check("init_ready_at_release", 64'(ready[0]), 64'(0));
        for (int c = 0; c < IW - 1; c++) begin
            tick();
            check("init_ready_low", 64'(ready[0]), 64'(0));
        end
        tick();
        check("init_ready_high", 64'(ready[0]), 64'(1));
        idle(4);

        // header + last on the non-stalling instance
        send(0, T_HDR, 32'h0123_4567);
        send(0, T_LST, 32'hDEAD_BEEF);
        check("pkt1_done",     64'(done[0]), 64'(1));
        check("pkt1_checksum", 64'(sum[0]),  64'h0000_0000_DF8E_FB88);
        check("pkt1_pkt_cnt",  64'(pc[0]),   64'(1));
        check("pkt1_flit_cnt", 64'(fc[0]),   64'(2));
        check("pkt1_error",    64'(err[0]),  64'(0));
        idle(1);
        check("pkt1_done_one_cycle", 64'(done[0]), 64'(0));

        // header followed by header: error 10, restart from the second header
        send(0, T_HDR, 32'h0000_0011);
        send(0, T_HDR, 32'h0000_0022);
        check("dup_hdr_error", 64'(err[0]),  64'(1));
        check("dup_hdr_code",  64'(code[0]), 64'(2));
        send(0, T_LST, 32'h0000_0044);
        check("dup_hdr_checksum", 64'(sum[0]), 64'h66);
        check("dup_hdr_pkt_cnt",  64'(pc[0]),  64'(2));
        check("dup_hdr_flit_cnt", 64'(fc[0]),  64'(5));
        idle(2);

        // stalling instance: stray last in WAIT_HDR, then a single
        send(1, T_LST, 32'h0);
        idle(1);
        check("stray_last_error",    64'(err[1]),  64'(1));
        check("stray_last_code",     64'(code[1]), 64'(1));
        check("stray_last_flit_cnt", 64'(fc[1]),   64'(1));
        check("stray_last_pkt_cnt",  64'(pc[1]),   64'(0));
        send(1, T_SGL, 32'h5);
        check("single_done",     64'(done[1]), 64'(1));
        check("single_checksum", 64'(sum[1]),  64'(5));
        check("single_code_kept", 64'(code[1]), 64'(1));
        idle(1);

        // 4-flit packet with valid held high across stalls
        d3_before = done_seen[1];
        send(1, T_HDR, 32'h10);
        send(1, T_PAY, 32'h21);
        send(1, T_PAY, 32'h42);
        send(1, T_LST, 32'h84);
        idle(2);
        check("stall_pkt_flit_cnt", 64'(fc[1]),  64'(6));
        check("stall_pkt_checksum", 64'(sum[1]), 64'hF7);
        check("stall_pkt_one_done", 64'(done_seen[1] - d3_before), 64'(1));

        // random traffic on both instances
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 2; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0);
                flit[i]  = {2'($urandom_range(0, 3)), 32'($urandom)};
            end
            tick();
        end
        idle(2);

        // clean reset, then abort a packet with reset mid-flight
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) model_reset(i);
        tick();
        rst = 1'b0;
        idle(IW + 1);
        send(0, T_HDR, 32'h55);
        valid[0] = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            model_reset(i);
            compare_all(i);
        end
        check("abort_no_done", 64'(done[0]), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        idle(IW + 1);
        send(0, T_HDR, 32'h0F);
        send(0, T_LST, 32'hF0);
        check("post_abort_done",     64'(done[0]), 64'(1));
        check("post_abort_checksum", 64'(sum[0]),  64'hFF);
        check("post_abort_pkt_cnt",  64'(pc[0]),   64'(1));
        check("post_abort_flit_cnt", 64'(fc[0]),   64'(2));
        check("post_abort_error",    64'(err[0]),  64'(0));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
